// File: rtl/draw_arbiter_if.sv
// draw_arbiter_if
// Bundles the requester-facing and engine-facing signals of the draw arbiter.
//   req        per-requester level request, held until its ack
//   req_x/y    packed 10-bit origins, requester i at [10i+9:10i]
//   req_color  packed 3-bit colours, requester i at [3i+2:3i]
//   draw_done  single-cycle completion pulse from the draw engine
//   eng_go     load strobe to the engine (falling edge starts the draw)
//   eng_x/y    latched origin, eng_color latched colour
//   grant      one-hot current owner, ack one-cycle completion pulse to owner
//   busy       arbiter not idle, timeout_err one-cycle watchdog abort pulse
// Modports: master = requesters + engine side, slave = the arbiter.
interface draw_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req;
  logic [NREQ*10-1:0] req_x;
  logic [NREQ*10-1:0] req_y;
  logic [NREQ*3-1:0]  req_color;
  logic               draw_done;
  logic               eng_go;
  logic [9:0]         eng_x;
  logic [9:0]         eng_y;
  logic [2:0]         eng_color;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    ack;
  logic               busy;
  logic               timeout_err;

  modport master (
    output req, req_x, req_y, req_color, draw_done,
    input  eng_go, eng_x, eng_y, eng_color, grant, ack, busy, timeout_err
  );

  modport slave (
    input  req, req_x, req_y, req_color, draw_done,
    output eng_go, eng_x, eng_y, eng_color, grant, ack, busy, timeout_err
  );
endinterface

// File: rtl/draw_arbiter.sv
// draw_arbiter
// Round-robin scheduler sharing one rectangle draw engine among NREQ
// screen-object requesters. The winner's origin and colour are latched,
// the engine is strobed for one cycle, and the arbiter waits for draw_done
// (or a watchdog expiry) before acknowledging the owner.
// Ports:
//   clk     system clock, all state on posedge
//   resetn  asynchronous active-low reset
//   bus     draw_arbiter_if slave modport (requests in, engine/grant/ack out)
// Parameters:
//   NREQ       number of requesters (2..8)
//   TIMEOUT_W  watchdog width; a draw is aborted after 2^TIMEOUT_W-1 busy cycles
module draw_arbiter #(
  parameter int NREQ      = 4,
  parameter int TIMEOUT_W = 16
) (
  input  logic          clk,
  input  logic          resetn,
  draw_arbiter_if.slave bus
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  // The counter is cleared when BUSY is entered, so the cycle in which it
  // holds all-ones-minus-one is the (2^W-1)th busy cycle: leave on that edge.
  localparam logic [TIMEOUT_W-1:0] WD_LAST = ~(TIMEOUT_W'(1));

  logic [1:0]           state_q,     state_d;
  logic [IDX_W-1:0]     last_q,      last_d;
  logic [NREQ-1:0]      grant_q,     grant_d;
  logic [9:0]           eng_x_q,     eng_x_d;
  logic [9:0]           eng_y_q,     eng_y_d;
  logic [2:0]           eng_color_q, eng_color_d;
  logic [TIMEOUT_W-1:0] wd_q,        wd_d;
  logic                 timeout_q,   timeout_d;

  logic                 found;
  logic [IDX_W-1:0]     win;
  logic [IDX_W-1:0]     cand;
  logic [9:0]           sel_x;
  logic [9:0]           sel_y;
  logic [2:0]           sel_color;

  // Rotating priority search starting just after the last owner; last_q
  // doubles as the owner index while a draw is in flight.
  always_comb begin
    found = 1'b0;
    win   = last_q;
    cand  = last_q;
    for (int i = 0; i < NREQ; i++) begin
      cand = IDX_W'((int'(last_q) + 1 + i) % NREQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    sel_x     = '0;
    sel_y     = '0;
    sel_color = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (win == IDX_W'(j)) begin
        sel_x     = bus.req_x[j*10 +: 10];
        sel_y     = bus.req_y[j*10 +: 10];
        sel_color = bus.req_color[j*3 +: 3];
      end
    end
  end

  // draw_done is only looked at in BUSY; a simultaneous done and expiry is
  // treated as a normal completion.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_d     = grant_q;
    eng_x_d     = eng_x_q;
    eng_y_d     = eng_y_q;
    eng_color_d = eng_color_q;
    wd_d        = wd_q;
    timeout_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d     = S_GRANT;
          last_d      = win;
          grant_d     = NREQ'(1) << win;
          eng_x_d     = sel_x;
          eng_y_d     = sel_y;
          eng_color_d = sel_color;
        end
      end
      S_GRANT: begin
        state_d = S_BUSY;
        wd_d    = '0;
      end
      S_BUSY: begin
        wd_d = wd_q + 1'b1;
        if (bus.draw_done) begin
          state_d = S_ACK;
        end else if (wd_q == WD_LAST) begin
          state_d   = S_ACK;
          timeout_d = 1'b1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      last_q      <= IDX_W'(NREQ - 1);
      grant_q     <= '0;
      eng_x_q     <= '0;
      eng_y_q     <= '0;
      eng_color_q <= '0;
      wd_q        <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      eng_x_q     <= eng_x_d;
      eng_y_q     <= eng_y_d;
      eng_color_q <= eng_color_d;
      wd_q        <= wd_d;
      timeout_q   <= timeout_d;
    end
  end

  // All outputs decode registered state only.
  assign bus.eng_go      = (state_q == S_GRANT);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.ack         = (state_q == S_ACK) ? grant_q : '0;
  assign bus.timeout_err = timeout_q;
  assign bus.grant       = grant_q;
  assign bus.eng_x       = eng_x_q;
  assign bus.eng_y       = eng_y_q;
  assign bus.eng_color   = eng_color_q;

endmodule

// File: tb/tb_draw_arbiter.sv
// tb_draw_arbiter
// Directed bench for draw_arbiter. One instance (TIMEOUT_W=8) covers the
// single request, stray done, dropped request, reset and round-robin cases;
// a second instance (TIMEOUT_W=4) covers the watchdog abort and the
// done-at-expiry boundary. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_draw_arbiter;

  logic clk = 1'b0;
  logic resetn;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  draw_arbiter_if #(.NREQ(4)) bus ();
  draw_arbiter_if #(.NREQ(4)) bus2 ();

  draw_arbiter #(.NREQ(4), .TIMEOUT_W(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  draw_arbiter #(.NREQ(4), .TIMEOUT_W(4)) dut_to (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus2)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Loads one requester's origin/colour slice on the main instance.
  task automatic applyStimulus(input int idx, input logic [9:0] x, input logic [9:0] y, input logic [2:0] c);
    bus.req_x[idx*10 +: 10]   = x;
    bus.req_y[idx*10 +: 10]   = y;
    bus.req_color[idx*3 +: 3] = c;
  endtask

  initial begin
    int busy_cycles;
    bit got_ack;

    resetn         = 1'b0;
    bus.req        = '0;
    bus.req_x      = '0;
    bus.req_y      = '0;
    bus.req_color  = '0;
    bus.draw_done  = 1'b0;
    bus2.req       = '0;
    bus2.req_x     = '0;
    bus2.req_y     = '0;
    bus2.req_color = '0;
    bus2.draw_done = 1'b0;

    // ---- reset state ----
    @(negedge clk);
    checkOutput("rst_busy",  32'(bus.busy), 32'd0);
    checkOutput("rst_grant", 32'(bus.grant), 32'd0);
    checkOutput("rst_go",    32'(bus.eng_go), 32'd0);
    checkOutput("rst_ack",   32'(bus.ack), 32'd0);
    checkOutput("rst_to",    32'(bus2.timeout_err), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // ---- single request, requester 2, done after 20 busy cycles ----
    applyStimulus(2, 10'd100, 10'd50, 3'b101);
    bus.req = 4'b0100;
    @(negedge clk);
    checkOutput("single_go",    32'(bus.eng_go), 32'd1);
    checkOutput("single_x",     32'(bus.eng_x), 32'd100);
    checkOutput("single_y",     32'(bus.eng_y), 32'd50);
    checkOutput("single_color", 32'(bus.eng_color), 32'd5);
    checkOutput("single_grant", 32'(bus.grant), 32'b0100);
    @(negedge clk);
    checkOutput("single_go_fall", 32'(bus.eng_go), 32'd0);
    repeat (19) @(negedge clk);
    checkOutput("single_noack",  32'(bus.ack), 32'd0);
    checkOutput("single_grant2", 32'(bus.grant), 32'b0100);
    bus.draw_done = 1'b1;
    @(negedge clk);
    bus.draw_done = 1'b0;
    checkOutput("single_ack", 32'(bus.ack), 32'b0100);
    checkOutput("single_to",  32'(bus.timeout_err), 32'd0);
    bus.req = 4'b0000;
    @(negedge clk);
    checkOutput("single_ack_once", 32'(bus.ack), 32'd0);
    checkOutput("single_idle",     32'(bus.busy), 32'd0);
    checkOutput("single_gclr",     32'(bus.grant), 32'd0);
    checkOutput("single_xhold",    32'(bus.eng_x), 32'd100);

    // ---- stray done in IDLE and GRANT, owner drops req mid-draw ----
    bus.draw_done = 1'b1;
    @(negedge clk);
    bus.draw_done = 1'b0;
    checkOutput("stray_idle", 32'(bus.busy), 32'd0);
    applyStimulus(1, 10'd321, 10'd123, 3'd3);
    bus.req = 4'b0010;
    @(negedge clk);
    checkOutput("stray_grant", 32'(bus.grant), 32'b0010);
    bus.draw_done = 1'b1;
    @(negedge clk);
    bus.draw_done = 1'b0;
    bus.req = 4'b0000;
    applyStimulus(1, 10'd7, 10'd8, 3'd0);
    checkOutput("stray_busy1", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stray_noack", 32'(bus.ack), 32'd0);
    end
    bus.draw_done = 1'b1;
    @(negedge clk);
    bus.draw_done = 1'b0;
    checkOutput("drop_ack",   32'(bus.ack), 32'b0010);
    checkOutput("drop_x",     32'(bus.eng_x), 32'd321);
    checkOutput("drop_y",     32'(bus.eng_y), 32'd123);
    checkOutput("drop_color", 32'(bus.eng_color), 32'd3);
    @(negedge clk);
    checkOutput("drop_idle", 32'(bus.busy), 32'd0);

    // ---- asynchronous reset in the middle of BUSY ----
    applyStimulus(3, 10'd500, 10'd400, 3'd6);
    bus.req = 4'b1000;
    @(negedge clk);
    checkOutput("rbusy_grant", 32'(bus.grant), 32'b1000);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    checkOutput("rbusy_busy",  32'(bus.busy), 32'd0);
    checkOutput("rbusy_grant0", 32'(bus.grant), 32'd0);
    checkOutput("rbusy_x",     32'(bus.eng_x), 32'd0);
    checkOutput("rbusy_color", 32'(bus.eng_color), 32'd0);
    bus.req = 4'b0000;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    checkOutput("rbusy_after", 32'(bus.busy), 32'd0);

    // ---- round robin, all four requesting, then wrap on re-request ----
    for (int k = 0; k < 4; k++) applyStimulus(k, 10'(10*k + 20), 10'(30 + k), 3'(k));
    bus.req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("rr_grant", 32'(bus.grant), 32'(1 << k));
      checkOutput("rr_x",     32'(bus.eng_x), 32'(10*k + 20));
      @(negedge clk);
      bus.draw_done = 1'b1;
      @(negedge clk);
      bus.draw_done = 1'b0;
      checkOutput("rr_ack", 32'(bus.ack), 32'(1 << k));
      bus.req[k] = 1'b0;
      @(negedge clk);
      checkOutput("rr_idle", 32'(bus.busy), 32'd0);
      if (k == 3) bus.req = 4'b1111;
    end
    @(negedge clk);
    checkOutput("rr_wrap", 32'(bus.grant), 32'b0001);
    @(negedge clk);
    bus.draw_done = 1'b1;
    @(negedge clk);
    bus.draw_done = 1'b0;
    checkOutput("rr_wrap_ack", 32'(bus.ack), 32'b0001);
    bus.req = 4'b0000;
    @(negedge clk);

    // ---- watchdog abort on the TIMEOUT_W=4 instance ----
    bus2.req = 4'b0001;
    @(negedge clk);
    checkOutput("to_go", 32'(bus2.eng_go), 32'd1);
    busy_cycles = 0;
    got_ack = 1'b0;
    for (int c = 0; c < 40 && !got_ack; c++) begin
      @(negedge clk);
      if (bus2.ack != 4'b0000) got_ack = 1'b1;
      else if (bus2.busy) busy_cycles++;
    end
    checkOutput("to_ack",    32'(bus2.ack), 32'b0001);
    checkOutput("to_err",    32'(bus2.timeout_err), 32'd1);
    checkOutput("to_cycles", 32'(busy_cycles), 32'd15);
    bus2.req = 4'b0000;
    @(negedge clk);
    checkOutput("to_err_once", 32'(bus2.timeout_err), 32'd0);
    checkOutput("to_idle",     32'(bus2.busy), 32'd0);

    // ---- done arriving in the expiry cycle wins over the timeout ----
    bus2.req = 4'b0001;
    @(negedge clk);
    repeat (15) @(negedge clk);
    checkOutput("edge_noack", 32'(bus2.ack), 32'd0);
    bus2.draw_done = 1'b1;
    @(negedge clk);
    bus2.draw_done = 1'b0;
    checkOutput("edge_ack", 32'(bus2.ack), 32'b0001);
    checkOutput("edge_err", 32'(bus2.timeout_err), 32'd0);
    bus2.req = 4'b0000;
    @(negedge clk);
    checkOutput("edge_idle", 32'(bus2.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
